zero_cross_rate_meter: RTL and testbench

Measures the zero-crossing rate of the signed audio sample stream and publishes it as a fixed-point `cpc` value with a one-cycle `cpc_en` strobe, once per analysis window. It sits directly upstream of the volume output decision stage and drives that stage's `cpc` / `cpc_en` inputs. It runs alongside the `vol` path in the same clock domain. Hysteresis rejects crossings caused by low-level noise.

---
 rtl/zero_cross_rate_meter_pkg.sv | 27 ++
 rtl/zero_cross_rate_meter_detector.sv | 54 +++++
 rtl/zero_cross_rate_meter.sv | 92 +++++++++
 tb/tb_zero_cross_rate_meter.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/zero_cross_rate_meter_pkg.sv
//------------------------------------------------------------------------------
// audio_meter_pkg : shared types and parameter helpers for the audio meters.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package audio_meter_pkg;

   typedef enum logic [1:0] {
      ST_UNKNOWN = 2'd0,
      ST_POS     = 2'd1,
      ST_NEG     = 2'd2
   } zc_state_t;

   // Left shift that turns a per-window count into Q.NUM_DECIMAL crossings per unit.
   function automatic int calc_shift(input int num_decimal, input int unit_log2,
                                     input int win_log2);
      return num_decimal + unit_log2 - win_log2;
   endfunction

   function automatic longint sat_limit(input int cpc_bits);
      return (longint'(1) << cpc_bits) - longint'(1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/zero_cross_rate_meter_detector.sv
//------------------------------------------------------------------------------
// zero_cross_detector : hysteresis sign tracker, pulses on a POS<->NEG change.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module zero_cross_detector
   import audio_meter_pkg::*;
#(
   parameter int VOL_BITS = 24,
   parameter int HYST     = 256
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       sample_valid,
   input  logic signed [VOL_BITS-1:0] sample,
   input  logic                       clear,
   output logic                       crossing
);

   localparam logic signed [VOL_BITS-1:0] HYST_P = VOL_BITS'(HYST);
   localparam logic signed [VOL_BITS-1:0] HYST_N = -HYST_P;

   zc_state_t state_q;
   zc_state_t state_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_UNKNOWN;
      end else begin
         state_q <= state_d;
      end
   end

   // Samples inside the closed band [-HYST, HYST] never move the state.
   always_comb begin
      state_d  = state_q;
      crossing = 1'b0;
      if (clear) begin
         state_d = ST_UNKNOWN;
      end else if (sample_valid) begin
         if (sample > HYST_P) begin
            state_d  = ST_POS;
            crossing = (state_q == ST_NEG);
         end else if (sample < HYST_N) begin
            state_d  = ST_NEG;
            crossing = (state_q == ST_POS);
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/zero_cross_rate_meter.sv
//------------------------------------------------------------------------------
// zero_cross_rate_meter : windowed zero-crossing rate, published as fixed-point cpc.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module zero_cross_rate_meter
   import audio_meter_pkg::*;
#(
   parameter int VOL_BITS    = 24,
   parameter int CPC_BITS    = 15,
   parameter int NUM_DECIMAL = 8,
   parameter int WIN_LOG2    = 10,
   parameter int UNIT_LOG2   = 6,
   parameter int HYST        = 256
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       sample_valid,
   input  logic signed [VOL_BITS-1:0] sample,
   input  logic                       clear,
   output logic                       cpc_en,
   output logic [CPC_BITS-1:0]        cpc
);

   localparam int SHIFT      = calc_shift(NUM_DECIMAL, UNIT_LOG2, WIN_LOG2);
   localparam int SHIFT_SAFE = (SHIFT < 0) ? 0 : SHIFT;
   localparam int SCALED_W   = WIN_LOG2 + 1 + SHIFT_SAFE;
   localparam logic [CPC_BITS-1:0] SAT_LIMIT = CPC_BITS'(sat_limit(CPC_BITS));

   if (SHIFT < 0) begin : g_shift_check
      $fatal(1, "zero_cross_rate_meter: NUM_DECIMAL+UNIT_LOG2 must be >= WIN_LOG2");
   end

   logic                crossing;
   logic [WIN_LOG2-1:0] win_cnt;
   logic [WIN_LOG2:0]   xcnt;
   logic [WIN_LOG2:0]   xcnt_final;
   logic [SCALED_W-1:0] scaled;
   logic [CPC_BITS-1:0] cpc_next;
   logic                win_end;

   zero_cross_detector #(
      .VOL_BITS (VOL_BITS),
      .HYST     (HYST)
   ) u_detector (
      .clk          (clk),
      .rst_n        (rst_n),
      .sample_valid (sample_valid),
      .sample       (sample),
      .clear        (clear),
      .crossing     (crossing)
   );

   // A crossing on the window-end sample still belongs to this window.
   assign xcnt_final = xcnt + {{WIN_LOG2{1'b0}}, crossing};
   assign win_end    = (win_cnt == {WIN_LOG2{1'b1}});
   assign scaled     = SCALED_W'(xcnt_final) << SHIFT_SAFE;

   if (SCALED_W > CPC_BITS) begin : g_sat
      assign cpc_next = (|scaled[SCALED_W-1:CPC_BITS]) ? SAT_LIMIT : scaled[CPC_BITS-1:0];
   end else begin : g_nosat
      assign cpc_next = CPC_BITS'(scaled);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win_cnt <= '0;
         xcnt    <= '0;
         cpc     <= '0;
         cpc_en  <= 1'b0;
      end else begin
         cpc_en <= 1'b0;
         if (clear) begin
            win_cnt <= '0;
            xcnt    <= '0;
         end else if (sample_valid) begin
            win_cnt <= win_cnt + 1'b1;
            if (win_end) begin
               xcnt   <= '0;
               cpc    <= cpc_next;
               cpc_en <= 1'b1;
            end else begin
               xcnt <= xcnt_final;
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_zero_cross_rate_meter.sv
//------------------------------------------------------------------------------
// tb_zero_cross_rate_meter : directed self-checking bench for zero_cross_rate_meter.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_zero_cross_rate_meter;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               sample_valid;
   logic signed [23:0] sample;
   logic               clear;
   logic               cpc_en_a, cpc_en_b;
   logic [14:0]        cpc_a, cpc_b;

   int n_checks = 0;
   int n_fail   = 0;
   int n_valid  = 0;
   int strobes  = 0;
   int spos [0:3];
   logic [14:0] sval_a [0:3];
   logic [14:0] sval_b [0:3];

   always #5 clk = ~clk;

   zero_cross_rate_meter u_dut_a (
      .clk (clk), .rst_n (rst_n), .sample_valid (sample_valid), .sample (sample),
      .clear (clear), .cpc_en (cpc_en_a), .cpc (cpc_a)
   );

   // Same stream into a UNIT_LOG2=7 instance to reach the saturation limit.
   zero_cross_rate_meter #(.UNIT_LOG2 (7)) u_dut_b (
      .clk (clk), .rst_n (rst_n), .sample_valid (sample_valid), .sample (sample),
      .clear (clear), .cpc_en (cpc_en_b), .cpc (cpc_b)
   );

   function automatic int sq(input int n);
      return (((n / 32) % 2) == 0) ? 1000 : -1000;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic push(input logic v, input int s, input logic clr);
      @(negedge clk);
      sample_valid = v;
      sample       = 24'(s);
      clear        = clr;
      @(posedge clk);
      #1;
      if (v && !clr) n_valid++;
      if (cpc_en_a) begin
         if (strobes < 4) begin
            spos[strobes]   = n_valid;
            sval_a[strobes] = cpc_a;
            sval_b[strobes] = cpc_b;
         end
         strobes++;
      end
   endtask

   task automatic restart_counts();
      n_valid = 0;
      strobes = 0;
      for (int i = 0; i < 4; i++) begin
         spos[i] = -1; sval_a[i] = '1; sval_b[i] = '1;
      end
   endtask

   initial begin
      rst_n = 1'b0; sample_valid = 1'b0; sample = '0; clear = 1'b0;
      restart_counts();
      @(posedge clk); @(posedge clk); #1;
      chk("reset_cpc", 64'(cpc_a), 64'd0);
      chk("reset_cpc_en", 64'(cpc_en_a), 64'd0);
      chk("reset_cpc_b", 64'(cpc_b), 64'd0);
      @(negedge clk); rst_n = 1'b1;

      // Square wave, period 64, starting positive
      restart_counts();
      for (int n = 0; n < 2048; n++) push(1'b1, sq(n), 1'b0);
      chk("sq_strobes", 64'(strobes), 64'd2);
      chk("sq_pos0", 64'(spos[0]), 64'd1024);
      chk("sq_pos1", 64'(spos[1]), 64'd2048);
      chk("sq_cpc0", 64'(sval_a[0]), 64'd496);
      chk("sq_cpc1", 64'(sval_a[1]), 64'd512);
      chk("sq_cpc0_b", 64'(sval_b[0]), 64'd992);
      chk("sq_cpc1_b", 64'(sval_b[1]), 64'd1024);
      push(1'b0, 0, 1'b0);
      chk("sq_strobe_one_cycle", 64'(cpc_en_a), 64'd0);
      chk("sq_cpc_stable", 64'(cpc_a), 64'd512);

      // Plain clear: cpc holds, no strobe
      push(1'b0, 0, 1'b1);
      chk("clear_no_strobe", 64'(cpc_en_a), 64'd0);
      chk("clear_cpc_hold", 64'(cpc_a), 64'd512);

      // Noise inside the band, including exactly +/-HYST
      restart_counts();
      for (int n = 0; n < 1024; n++) begin
         case (n % 8)
            0: push(1'b1, 256, 1'b0);
            1: push(1'b1, -256, 1'b0);
            2: push(1'b1, 0, 1'b0);
            3: push(1'b1, 100, 1'b0);
            4: push(1'b1, -200, 1'b0);
            5: push(1'b1, 255, 1'b0);
            6: push(1'b1, -255, 1'b0);
            default: push(1'b1, 1, 1'b0);
         endcase
      end
      chk("noise_strobes", 64'(strobes), 64'd1);
      chk("noise_pos", 64'(spos[0]), 64'd1024);
      chk("noise_cpc", 64'(sval_a[0]), 64'd0);
      chk("noise_cpc_b", 64'(sval_b[0]), 64'd0);

      // +/-300 alternating from UNKNOWN: 1023 crossings
      restart_counts();
      for (int n = 0; n < 1024; n++) push(1'b1, (n % 2 == 0) ? 300 : -300, 1'b0);
      chk("alt300_cpc", 64'(sval_a[0]), 64'd16368);
      chk("alt300_cpc_b", 64'(sval_b[0]), 64'd32736);

      // +/-1000 alternating from NEG: 1024 crossings, saturates in the x128 unit
      restart_counts();
      for (int n = 0; n < 1024; n++) push(1'b1, (n % 2 == 0) ? 1000 : -1000, 1'b0);
      chk("alt1000_strobes", 64'(strobes), 64'd1);
      chk("alt1000_cpc", 64'(sval_a[0]), 64'd16384);
      chk("sat_cpc_b", 64'(sval_b[0]), 64'd32767);

      // Square wave at 1/3 valid duty; invalid cycles carry inverted garbage
      push(1'b0, 0, 1'b1);
      restart_counts();
      for (int n = 0; n < 2048; n++) begin
         push(1'b1, sq(n), 1'b0);
         push(1'b0, -sq(n), 1'b0);
         push(1'b0, -sq(n), 1'b0);
      end
      chk("gap_strobes", 64'(strobes), 64'd2);
      chk("gap_pos0", 64'(spos[0]), 64'd1024);
      chk("gap_pos1", 64'(spos[1]), 64'd2048);
      chk("gap_cpc0", 64'(sval_a[0]), 64'd496);
      chk("gap_cpc1", 64'(sval_a[1]), 64'd512);

      // Reset asserted mid-window after 500 valid samples
      push(1'b0, 0, 1'b1);
      restart_counts();
      for (int n = 0; n < 500; n++) push(1'b1, sq(n), 1'b0);
      @(negedge clk); sample_valid = 1'b0; #2; rst_n = 1'b0; #1;
      chk("rst_async_cpc", 64'(cpc_a), 64'd0);
      chk("rst_async_cpc_en", 64'(cpc_en_a), 64'd0);
      @(posedge clk); @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      restart_counts();
      for (int n = 500; n < 1524; n++) push(1'b1, sq(n), 1'b0);
      chk("rst_strobes", 64'(strobes), 64'd1);
      chk("rst_pos", 64'(spos[0]), 64'd1024);
      chk("rst_cpc", 64'(sval_a[0]), 64'd512);

      // clear together with sample_valid at sample 700
      push(1'b0, 0, 1'b1);
      restart_counts();
      for (int n = 0; n < 700; n++) push(1'b1, sq(n), 1'b0);
      chk("clrv_no_early", 64'(strobes), 64'd0);
      push(1'b1, sq(700), 1'b1);
      chk("clrv_no_strobe", 64'(cpc_en_a), 64'd0);
      chk("clrv_cpc_hold", 64'(cpc_a), 64'd512);
      restart_counts();
      for (int n = 0; n < 1024; n++) push(1'b1, (n % 2 == 0) ? 300 : -300, 1'b0);
      chk("clrv_strobes", 64'(strobes), 64'd1);
      chk("clrv_pos", 64'(spos[0]), 64'd1024);
      chk("clrv_cpc", 64'(sval_a[0]), 64'd16368);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
